// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: receive-only PS/2 device-to-host deserializer.
// Synchronizes and glitch-filters the raw PS/2 lines, frames 11-bit packets
// (start, 8 data LSB-first, odd parity, stop) and delivers each good byte
// with a one-cycle strobe.
//
// Ports:
//   CLOCK_50         in   system clock (single domain)
//   reset            in   synchronous active-high reset
//   ps2_clk_in       in   raw PS/2 clock line (async, idle high)
//   ps2_dat_in       in   raw PS/2 data line (async, idle high)
//   received_data    out  last good byte, held until the next good byte
//   received_data_en out  one-cycle strobe, received_data valid same cycle
//   frame_error      out  one-cycle strobe: bad start/stop/parity or timeout
//   busy             out  high while a frame is in progress
//
// Optional build macro: PS2_PARITY_CHECK_EN
//   defined   -> frames with bad parity are rejected with frame_error
//   undefined -> parity bit is captured but ignored
module ps2_frame_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned FCNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  // Expire on the cycle the counter would step onto TIMEOUT_CYCLES-1.
  localparam logic [TCNT_W-1:0] TCNT_EXPIRE = TCNT_W'(TIMEOUT_CYCLES - 2);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_CHECK = 1'b1;
`else
  localparam logic PARITY_CHECK = 1'b0;
`endif

  // The start bit is consumed directly in IDLE, so no separate START state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic                dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic                filt_clk_q, filt_clk_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                fall_tick_q, fall_tick_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [TCNT_W-1:0]   tmo_q, tmo_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_en_q, rx_en_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                frame_ok_c;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_clk_q  <= 1'b1;
      fcnt_q      <= '0;
      fall_tick_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      rx_data_q   <= '0;
      rx_en_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_clk_q  <= filt_clk_d;
      fcnt_q      <= fcnt_d;
      fall_tick_q <= fall_tick_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      rx_data_q   <= rx_data_d;
      rx_en_q     <= rx_en_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Frame acceptance in STOP: stop bit high and, if enabled, odd parity.
  assign frame_ok_c = dat_s2_q & ((^{shift_q, parity_q}) | ~PARITY_CHECK);

  // Synchronizers, clock filter, framing FSM and timeout
  always_comb begin
    state_d     = state_q;
    clk_s1_d    = ps2_clk_in;
    clk_s2_d    = clk_s1_q;
    dat_s1_d    = ps2_dat_in;
    dat_s2_d    = dat_s1_q;
    filt_clk_d  = filt_clk_q;
    fcnt_d      = '0;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_d       = '0;
    rx_data_d   = rx_data_q;
    rx_en_d     = 1'b0;
    err_d       = 1'b0;

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    if (clk_s2_q != filt_clk_q) begin
      if (fcnt_q == FCNT_LAST) begin
        filt_clk_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
    fall_tick_d = filt_clk_q & ~filt_clk_d;

    if (fall_tick_q) begin
      // A falling edge always wins over a coincident timeout.
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = dat_s2_q;
          if (bit_cnt_q == 3'd7) begin
            state_d   = PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          parity_d = dat_s2_q;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (frame_ok_c) begin
            rx_data_d = shift_q;
            rx_en_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TCNT_EXPIRE) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        err_d     = 1'b1;
      end else begin
        tmo_d = tmo_q + TCNT_W'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign received_data    = rx_data_q;
  assign received_data_en = rx_en_q;
  assign frame_error      = err_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: randomized and directed PS/2 frames checked against
// an event-level reference model (expected strobe cycle, kind and byte).
module tb_ps2_frame_receiver;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 200;
  // Raw clock fall driven in cycle N -> filtered fall_tick in cycle N+TICK_LAT
  // (2 synchronizer stages plus FILTER_LEN filter samples).
  localparam int TICK_LAT   = 2 + FILTER_LEN;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       frame_error;
  logic       busy;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         overlap = 0;
  int         last_fall = 0;
  logic [7:0] last_good = 8'h00;
  ev_t        exp_q[$];
  ev_t        obs_q[$];

  ps2_frame_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .ps2_clk_in      (ps2_clk),
    .ps2_dat_in      (ps2_dat),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .frame_error     (frame_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (received_data_en) obs_q.push_back('{cyc, 1'b0, received_data});
    if (frame_error)      obs_q.push_back('{cyc, 1'b1, 8'h00});
    if (received_data_en && frame_error) overlap++;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set during the high phase, then a full low phase.
  task automatic drive_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2_dat = b;
    if (glitch) begin
      wait_cycles(HALF / 2);
      ps2_clk = 1'b0;
      wait_cycles(2);
      ps2_clk = 1'b1;
      wait_cycles(HALF / 2 - 2);
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk   = 1'b0;
    last_fall = cyc;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) drive_bit(bits[i], i == glitch_bit);
  endtask

  // Full frame plus the model's expected outcome for it.
  task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                            input int glitch_bit);
    logic par;
    bool_ok: begin end
    par = (~^d) ^ par_flip;
    send_bits({stop, par, d, 1'b0}, 11, glitch_bit);
    if (stop && (!par_flip || !PAR_CHK)) begin
      exp_q.push_back('{last_fall + TICK_LAT + 1, 1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back('{last_fall + TICK_LAT + 1, 1'b1, 8'h00});
    end
  endtask

  task automatic compare_events(input string tag);
    wait_cycles(20);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_cyc"}, obs_q[i].cyc, exp_q[i].cyc);
      check({tag, "_kind"}, 32'(obs_q[i].is_err), 32'(exp_q[i].is_err));
      if (!exp_q[i].is_err) check({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_held"}, 32'(received_data), 32'(last_good));
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    // Reset values
    wait_cycles(5);
    check("rst_data", 32'(received_data), 0);
    check("rst_en", 32'(received_data_en), 0);
    check("rst_err", 32'(frame_error), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(20);

    send_frame(8'h33, 1'b0, 1'b1, -1);
    compare_events("single_33");

    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h1B, 1'b0, 1'b1, -1);
    compare_events("b2b");

    send_frame(8'h23, 1'b0, 1'b1, 4);
    compare_events("glitch");

    send_frame(8'h23, 1'b0, 1'b0, -1);
    compare_events("bad_stop");

    // Start plus 3 data bits, then the clock stays high.
    send_bits({8'b0000_0110, 1'b0}, 4, -1);
    check("busy_mid", 32'(busy), 1);
    exp_q.push_back('{last_fall + TICK_LAT + TIMEOUT, 1'b1, 8'h00});
    wait_cycles(TIMEOUT + 50);
    compare_events("timeout");
    send_frame(8'h1B, 1'b0, 1'b1, -1);
    compare_events("after_tmo");

    send_frame(8'h33, 1'b1, 1'b1, -1);
    compare_events("par_flip");

    // Single clock pulse with data high in IDLE is a bad start.
    drive_bit(1'b1, 1'b0);
    exp_q.push_back('{last_fall + TICK_LAT + 1, 1'b1, 8'h00});
    compare_events("bad_start");

    for (int n = 0; n < 6; n++) begin
      logic [7:0] d;
      bit         pf;
      logic       st;
      int         gb;
      d  = 8'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 6) != 0);
      gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
      send_frame(d, pf, st, gb);
    end
    compare_events("random");

    // Reset mid-frame discards the partial frame without a strobe.
    send_bits({8'b1010_0101, 1'b0}, 5, -1);
    ps2_dat = 1'b1;
    reset   = 1'b1;
    wait_cycles(3);
    check("mid_rst_data", 32'(received_data), 0);
    check("mid_rst_en", 32'(received_data_en), 0);
    check("mid_rst_err", 32'(frame_error), 0);
    check("mid_rst_busy", 32'(busy), 0);
    last_good = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(TIMEOUT + 200);
    compare_events("mid_rst");
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    compare_events("post_rst");

    check("en_err_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Receive-only PS/2 device-to-host deserializer. It feeds the keyboard scan-code decoder that produces the hit/stand/deal pulses.
- Takes the raw PS2_CLK/PS2_DAT lines, then synchronizes, glitch-filters and frames each 11-bit packet (start, 8 data LSB-first, odd parity, stop).
- Delivers each good byte with a one-cycle strobe (received_data / received_data_en), the contract the decoder consumes.
- Flags malformed or stalled frames on frame_error.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level (range 2..255).
- TIMEOUT_CYCLES, 50000: CLOCK_50 cycles without a filtered falling edge, while mid-frame, before the frame is aborted (1 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous, idle high).
- ps2_dat_in  in  1  raw PS/2 data line (asynchronous, idle high).
- received_data  out  8  last correctly received byte; held until the next good byte.
- received_data_en  out  1  one-cycle strobe; received_data is valid in the same cycle.
- frame_error  out  1  one-cycle strobe on a bad start, stop or parity bit, or on timeout.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: received_data=8'h00, received_data_en=0, frame_error=0, busy=0, state=IDLE, bit counter=0, shift register=0, timeout counter=0, filtered clock=1, synchronizers=1. Reset applies from any state, including mid-frame; no strobe is issued for the aborted frame.
- Synchronization: both inputs pass through 2-flop synchronizers.
- Clock filter: a counter tracks run length of the synchronized clock differing from the filtered value. When the run reaches FILTER_LEN, the filtered value flips and the counter clears. Any sample equal to the filtered value clears the counter.
- Falling edge: fall_tick=1 for exactly one cycle when the filtered clock goes 1->0.
- Data sampling: data is sampled on the fall_tick cycle from the synchronized data line.
- IDLE:
  - on fall_tick, data=0 -> START, then DATA with bit counter=0;
  - on fall_tick, data=1 -> stay in IDLE and pulse frame_error (bad start).
- DATA: each fall_tick shifts the data bit into bit[counter], LSB first. After the 8th bit -> PARITY.
- PARITY: fall_tick captures the parity bit -> STOP.
- STOP: fall_tick samples the stop bit, then -> IDLE. Strobe rules:
  - stop=1 and frame good: received_data updates and received_data_en=1 in the cycle after fall_tick (latency 1 cycle from the stop-bit fall_tick).
  - stop=0: frame_error=1 in the same slot; received_data unchanged; no en.
- received_data_en and frame_error are never high in the same cycle.
- Timeout:
  - the timeout counter resets on every fall_tick and increments while state != IDLE;
  - on reaching TIMEOUT_CYCLES-1: state -> IDLE, frame_error pulses one cycle, partial byte discarded;
  - in IDLE the counter is held at 0.
- Simultaneous events: if fall_tick arrives in the same cycle as the timeout expiry, fall_tick wins (the counter clears and framing proceeds).
- Back-to-back frames: a new start bit is accepted on the first fall_tick after returning to IDLE; no inter-frame gap is required.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: in STOP, the frame is good only if the 8 data bits plus the parity bit have an odd count of ones. A parity mismatch with a valid stop bit -> frame_error pulse, no received_data_en, received_data unchanged.
- Undefined: the parity bit is captured but ignored. Any frame with start=0 and stop=1 is delivered; frame_error never fires for parity.

Test Plan (benches set TIMEOUT_CYCLES=2000 and FILTER_LEN=4; PS/2 half-period is 200 cycles):
- Send 0x33 (parity 1, stop 1) -> exactly one received_data_en pulse with received_data=8'h33, 1 cycle after the stop-bit fall_tick; frame_error stays 0; busy returns to 0.
- Send 0xF0 then 0x1B back-to-back with no gap -> two en pulses carrying 8'hF0 then 8'h1B; no frame_error.
- Send 0x23 with a 2-cycle low glitch injected mid-bit on ps2_clk_in -> glitch filtered out; en with 8'h23.
- Send 0x23 with stop bit driven 0 -> frame_error pulses once; no en; received_data keeps its previous value.
- Send start plus 3 data bits, then hold the clock high -> frame_error exactly 2000 cycles after the last fall_tick; busy goes 0. A following 0x1B is received correctly.
- Send 0x33 with parity forced 0:
  - with PS2_PARITY_CHECK_EN defined -> frame_error, no en;
  - without it -> en with 8'h33.
  - Also assert reset mid-frame -> all outputs return to reset values, no strobe.
